// File: rtl/multicycle_pkg.sv
// Shared opcodes, ALU codes, FSM states, control bundle and boot image for the
// multicycle MIPS-subset core.
package multicycle_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 64;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StRtypeEx, StRtypeWb, StAddiEx, StAddiWb, StBeqEx, StJEx
    } state_e;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluctl;
    } ctl_t;

    // Word 0 is the least significant element.
    localparam logic [MEM_WORDS_DEFAULT-1:0][31:0] BOOT_IMAGE = {
        {(MEM_WORDS_DEFAULT - 5){32'h0000_0000}},
        32'h0800_0004, 32'hAC04_0028, 32'h0043_2020, 32'h2003_002C, 32'h2002_0005
    };

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_controller.sv
// Multicycle FSM and ALU decoder; all datapath controls are registered alongside the state.
module mc_controller
    import multicycle_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output ctl_t       ctl_o
);

    state_e state_q, state_d;
    ctl_t   ctl_q;

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
    endfunction

    function automatic logic [2:0] alu_dec(input logic [5:0] f);
        logic [2:0] c;
        case (f)
            FN_SUB:  c = ALU_SUB;
            FN_AND:  c = ALU_AND;
            FN_OR:   c = ALU_OR;
            FN_SLT:  c = ALU_SLT;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

    function automatic ctl_t state_ctl(input state_e s, input logic [5:0] f);
        ctl_t c;
        c        = '0;
        c.aluctl = ALU_ADD;
        case (s)
            StFetch: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = SRCB_FOUR;
            end
            StDecode: c.alusrcb = SRCB_IMM_SH2;
            StMemAdr, StAddiEx: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            StMemRd: c.iord = 1'b1;
            StMemWb: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            StMemWr: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            StRtypeEx: begin
                c.alusrca = 1'b1;
                c.aluctl  = alu_dec(f);
            end
            StRtypeWb: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            StAddiWb: c.regwrite = 1'b1;
            StBeqEx: begin
                c.alusrca = 1'b1;
                c.aluctl  = ALU_SUB;
                c.branch  = 1'b1;
                c.pcsrc   = PC_ALUOUT;
            end
            StJEx: begin
                c.pcwrite = 1'b1;
                c.pcsrc   = PC_JUMP;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = funct_ok(funct_i) ? StRtypeEx : StFetch;
                    OP_BEQ:       state_d = StBeqEx;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJEx;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (op_i == OP_LW) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StRtypeEx: state_d = StRtypeWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    // The IR already holds the new instruction when DECODE is left, so funct is valid here.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StFetch;
            ctl_q   <= state_ctl(StFetch, funct_i);
        end else begin
            state_q <= state_d;
            ctl_q   <= state_ctl(state_d, funct_i);
        end
    end

    assign ctl_o = ctl_q;

endmodule

// File: rtl/multicycle_top.sv
// Multicycle MIPS-subset core with unified instruction/data memory; only the memory
// write bus is exposed.
module multicycle_top
    import multicycle_pkg::*;
#(
    parameter int unsigned                MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter logic [31:0]                RESET_PC  = 32'h0000_0000,
    parameter logic [MEM_WORDS-1:0][31:0] MEM_INIT  = BOOT_IMAGE
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata,
    output logic [31:0] dataadr,
    output logic        memwrite
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    ctl_t                       ctl;
    logic [31:0]                pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [31:0]                rf_q [32];
    logic [MEM_WORDS-1:0][31:0] mem_q = MEM_INIT;

    logic [4:0]  rs, rt, rd, wb_addr;
    logic [31:0] imm_ext, rs_data, rt_data, addr, rd_data;
    logic [31:0] src_a, src_b, alu_y, pc_d, wb_data;
    logic        zero, pc_en;

    mc_controller u_ctrl (
        .clk_i  (clk),
        .reset_i(reset),
        .op_i   (ir_q[31:26]),
        .funct_i(ir_q[5:0]),
        .ctl_o  (ctl)
    );

    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign imm_ext = sign_ext(ir_q[15:0]);
    assign rs_data = (rs == 5'd0) ? '0 : rf_q[rs];
    assign rt_data = (rt == 5'd0) ? '0 : rf_q[rt];
    assign addr    = ctl.iord ? aluout_q : pc_q;
    assign rd_data = mem_q[addr[AW+1:2]];
    assign src_a   = ctl.alusrca ? a_q : pc_q;
    assign wb_addr = ctl.regdst ? rd : rt;
    assign wb_data = ctl.memtoreg ? mdr_q : aluout_q;
    assign zero    = (alu_y == '0);
    assign pc_en   = ctl.pcwrite | (ctl.branch & zero);

    always_comb begin
        src_b = b_q;
        case (ctl.alusrcb)
            SRCB_REG:  src_b = b_q;
            SRCB_FOUR: src_b = 32'd4;
            SRCB_IMM:  src_b = imm_ext;
            default:   src_b = {imm_ext[29:0], 2'b00};
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (ctl.aluctl)
            ALU_ADD: alu_y = src_a + src_b;
            ALU_SUB: alu_y = src_a - src_b;
            ALU_AND: alu_y = src_a & src_b;
            ALU_OR:  alu_y = src_a | src_b;
            ALU_SLT: alu_y = {31'b0, $signed(src_a) < $signed(src_b)};
            default: alu_y = src_a + src_b;
        endcase
    end

    always_comb begin
        pc_d = alu_y;
        case (ctl.pcsrc)
            PC_ALU:    pc_d = alu_y;
            PC_ALUOUT: pc_d = aluout_q;
            default:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        endcase
    end

    // A, B, MDR and ALUOut reload every cycle; each value is only consumed in the state after
    // the one that produced it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            if (pc_en) pc_q <= pc_d;
            if (ctl.irwrite) ir_q <= rd_data;
            mdr_q    <= rd_data;
            a_q      <= rs_data;
            b_q      <= rt_data;
            aluout_q <= alu_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (ctl.regwrite && (wb_addr != 5'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (memwrite) mem_q[addr[AW+1:2]] <= b_q;
    end

    // Reset masks the bus so an interrupted store never reaches memory.
    assign memwrite  = ctl.memwrite & ~reset;
    assign dataadr   = reset ? '0 : addr;
    assign writedata = reset ? '0 : b_q;

endmodule

// File: tb/tb_multicycle_top.sv
// Bench for multicycle_top: an instruction-level reference model predicts fetch addresses
// and store traffic every cycle for the boot image and an alternate image.
module tb_multicycle_top;

    localparam logic [63:0][31:0] BOOT = {
        {59{32'h0}}, 32'h0800_0004, 32'hAC04_0028, 32'h0043_2020, 32'h2003_002C, 32'h2002_0005
    };
    // lw $5,80; beq $5,$5,+1; sw $5,84 (skipped); addi $6,$0,1; sub/and/or/slt; four sw; j self.
    localparam logic [63:0][31:0] ALT = {
        {43{32'h0}}, 32'hFFFF_FFFF, {7{32'h0}},
        32'h0800_000C, 32'hAC0A_0064, 32'hAC09_0060, 32'hAC08_005C, 32'hAC07_0058,
        32'h00A6_502A, 32'h00A6_4825, 32'h00A6_4024, 32'h00C5_3822, 32'h2006_0001,
        32'hAC05_0054, 32'h10A5_0001, 32'h8C05_0050
    };

    logic        clk;
    logic        rst0, rst1, mw0, mw1;
    logic [31:0] wd0, wd1, da0, da1;

    int n_cmp  = 0;
    int n_fail = 0;

    int          relcyc [2], mcyc [2], mlen [2], pulses [2], pulse_cyc [2];
    logic [31:0] mpc [2], mir [2], pulse_addr [2], pulse_data [2];
    logic [31:0] mrf [2][32];
    logic [31:0] mmem [2][64];
    logic [31:0] da_log [2][64];
    logic [63:0] stq0 [$];
    logic [63:0] stq1 [$];

    multicycle_top #(.MEM_WORDS(64), .RESET_PC(32'h0)) dut0 (
        .clk(clk), .reset(rst0), .writedata(wd0), .dataadr(da0), .memwrite(mw0)
    );
    multicycle_top #(.MEM_WORDS(64), .RESET_PC(32'h0), .MEM_INIT(ALT)) dut1 (
        .clk(clk), .reset(rst1), .writedata(wd1), .dataadr(da1), .memwrite(mw1)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input int id, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h, expected %h (t=%0t)", id, name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
    endfunction

    function automatic int instr_len(input logic [31:0] ir);
        case (ir[31:26])
            6'h00:        return funct_ok(ir[5:0]) ? 4 : 2;
            6'h23:        return 5;
            6'h2B, 6'h08: return 4;
            6'h04, 6'h02: return 3;
            default:      return 2;
        endcase
    endfunction

    // Architectural effect of one whole instruction.
    task automatic execute(input int id);
        logic [31:0] ir, a, b, pc4, ea;
        ir  = mir[id];
        a   = mrf[id][ir[25:21]];
        b   = mrf[id][ir[20:16]];
        ea  = a + sext(ir[15:0]);
        pc4 = mpc[id] + 32'd4;
        mpc[id] = pc4;
        case (ir[31:26])
            6'h00: begin
                case (ir[5:0])
                    6'h20: mrf[id][ir[15:11]] = a + b;
                    6'h22: mrf[id][ir[15:11]] = a - b;
                    6'h24: mrf[id][ir[15:11]] = a & b;
                    6'h25: mrf[id][ir[15:11]] = a | b;
                    6'h2A: mrf[id][ir[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: ;
                endcase
            end
            6'h23: mrf[id][ir[20:16]] = mmem[id][ea[7:2]];
            6'h04: if (a == b) mpc[id] = pc4 + (sext(ir[15:0]) << 2);
            6'h08: mrf[id][ir[20:16]] = ea;
            6'h02: mpc[id] = {pc4[31:28], ir[25:0], 2'b00};
            default: ;
        endcase
        mrf[id][0] = '0;
    endtask

    task automatic cycle_check(input int id, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ir, ea, rt_v;
        logic        is_st;
        if (r) begin
            chk(id, "reset_memwrite", {31'b0, w}, 32'd0);
            chk(id, "reset_dataadr", a, 32'd0);
            chk(id, "reset_writedata", d, 32'd0);
            relcyc[id] = 0;
            mcyc[id]   = 0;
            mpc[id]    = 32'd0;
            pulses[id] = 0;
            for (int i = 0; i < 32; i++) mrf[id][i] = '0;
            if (id == 0) stq0.delete();
            else stq1.delete();
        end else begin
            relcyc[id]++;
            if (relcyc[id] < 64) da_log[id][relcyc[id]] = a;
            if (mcyc[id] == 0) begin
                mir[id]  = mmem[id][mpc[id][7:2]];
                mlen[id] = instr_len(mir[id]);
                chk(id, "fetch_addr", a, mpc[id]);
            end
            ir    = mir[id];
            rt_v  = mrf[id][ir[20:16]];
            ea    = mrf[id][ir[25:21]] + sext(ir[15:0]);
            is_st = (ir[31:26] == 6'h2B) && (mcyc[id] == 3);
            chk(id, "memwrite", {31'b0, w}, {31'b0, is_st});
            if (w) begin
                pulses[id]++;
                pulse_cyc[id]  = relcyc[id];
                pulse_addr[id] = a;
                pulse_data[id] = d;
                if (id == 0) stq0.push_back({a, d});
                else stq1.push_back({a, d});
            end
            if (is_st) begin
                chk(id, "store_addr", a, ea);
                chk(id, "store_data", d, rt_v);
                mmem[id][ea[7:2]] = rt_v;
            end
            mcyc[id]++;
            if (mcyc[id] == mlen[id]) begin
                execute(id);
                mcyc[id] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        cycle_check(0, rst0, mw0, da0, wd0);
        cycle_check(1, rst1, mw1, da1, wd1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_boot_store(input string tag);
        chk(0, {tag, "_pulse_count"}, pulses[0], 32'd1);
        chk(0, {tag, "_pulse_cycle"}, pulse_cyc[0], 32'd16);
        chk(0, {tag, "_pulse_addr"}, pulse_addr[0], 32'd40);
        chk(0, {tag, "_pulse_data"}, pulse_data[0], 32'd49);
    endtask

    initial begin
        logic [63:0][31:0] img0, img1;
        logic [31:0]       exp_a [4];
        logic [31:0]       exp_d [4];
        logic [63:0]       e;
        img0 = BOOT;
        img1 = ALT;
        for (int i = 0; i < 64; i++) begin
            mmem[0][i] = img0[i];
            mmem[1][i] = img1[i];
        end
        exp_a = '{32'd88, 32'd92, 32'd96, 32'd100};
        exp_d = '{32'd2, 32'd1, 32'hFFFF_FFFF, 32'd1};
        rst0 = 1'b1;
        rst1 = 1'b1;

        // Reset for one edge, then run the boot program.
        @(posedge clk);
        #2;
        rst0 = 1'b0;
        cycles(30);
        chk(0, "first_fetch_addr", da_log[0][1], 32'd0);
        chk(0, "second_fetch_addr", da_log[0][5], 32'd4);
        check_boot_store("boot");
        cycles(20);
        chk(0, "spin_fetch_47", da_log[0][47], 32'h10);
        chk(0, "spin_fetch_50", da_log[0][50], 32'h10);
        chk(0, "spin_no_more_stores", pulses[0], 32'd1);
        chk(0, "mem_word10", dut0.mem_q[10], 32'd49);

        // Reset during ADDIWB of the second instruction (cycle 8).
        rst0 = 1'b1;
        cycles(1);
        rst0 = 1'b0;
        cycles(7);
        rst0 = 1'b1;
        cycles(1);
        rst0 = 1'b0;
        cycles(30);
        check_boot_store("restart");

        // Random reset points and reset lengths.
        for (int t = 0; t < 5; t++) begin
            cycles($urandom_range(1, 40));
            rst0 = 1'b1;
            cycles($urandom_range(1, 3));
            rst0 = 1'b0;
        end
        cycles(30);
        check_boot_store("random");

        // Alternate image: taken branch, skipped store, R-type results stored.
        rst1 = 1'b0;
        cycles(70);
        chk(1, "alt_store_count", stq1.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < stq1.size()) begin
                e = stq1[i];
                chk(1, "alt_store_addr", e[63:32], exp_a[i]);
                chk(1, "alt_store_data", e[31:0], exp_d[i]);
            end
        end
        chk(1, "alt_skipped_word21", dut1.mem_q[21], 32'd0);
        chk(1, "alt_slt_word25", dut1.mem_q[25], 32'd1);
        chk(1, "model_sub", mrf[1][7], 32'd2);
        chk(1, "model_slt", mrf[1][10], 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
